wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive cycles a pending aux write may lose to the pipeline (range 1..15).
REQ-002 SHALL have parameter AUX_DEPTH, default 2, meaning the aux holding FIFO depth (fixed power of two, 2 or 4).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pipe_we  in  1  MEM/WB register-write control.
REQ-006 pipe_waddr  in  5  MEM/WB destination register.
REQ-007 pipe_wdata  in  32  MEM/WB write data.
REQ-008 pipe_stall  out  1  freeze request to the MEM/WB stage; pipe_* held stable by the pipeline while high.
REQ-009 aux_valid  in  1  secondary requester (multi-cycle unit) write request.
REQ-010 aux_waddr / aux_wdata  in  5 / 32  secondary destination and data.
REQ-011 aux_ready  out  1  FIFO can accept; transfer when aux_valid & aux_ready.
REQ-012 rf_we / rf_waddr / rf_wdata  out  1 / 5 / 32  registered register-file write port.
REQ-013 hold_we / hold_waddr / hold_wdata  out  1 / 5 / 32  previous-cycle write copy for ID-stage forwarding.

Function
REQ-014 Pipe request = pipe_we & (pipe_waddr != 0); writes to register 0 are never driven onto rf_we.
REQ-015 Aux transfers to register 0 are accepted (FIFO pushed) and discarded at grant (rf_we stays 0).
REQ-016 aux_ready = (FIFO count < AUX_DEPTH), combinational from registered count; push never occurs when full.
REQ-017 Push and pop in one cycle: count unchanged, FIFO order preserved; pop from empty never occurs.
REQ-018 Grant aux when FIFO non-empty and (no pipe request or starve_cnt == STARVE_LIMIT); otherwise grant pipe if pipe request.
REQ-019 pipe_stall = pipe request & aux granted, combinational, same cycle.
REQ-020 starve_cnt: increments when FIFO non-empty and pipe granted; clears when aux granted or FIFO empty; saturates at STARVE_LIMIT.
REQ-021 Granted write appears on rf_* at the next rising edge (latency 1); rf_we = 0 in cycles with no grant, rf_waddr/rf_wdata hold last values.
REQ-022 Aux writes issue in FIFO arrival order; WAW ordering between aux and pipe to the same register is the issuing logic's responsibility (scoreboard), not this block's.
REQ-023 Maximum aux wait after reaching FIFO head: STARVE_LIMIT+1 cycles.

Reset
REQ-024 While rst high at a clock edge: FIFO count, pointers, starve_cnt, rf_we, rf_waddr, rf_wdata, hold_* all cleared to 0.
REQ-025 While rst high: aux_ready = 0 and pipe_stall = 0; any in-flight aux entries are discarded (mid-operation reset loses queued writes).
REQ-026 First grant possible in the cycle after rst deasserts.

Configuration
REQ-027 Macro WB_ARB_HOLD_EN defined: hold_* register rf_* one cycle later (rf_* at cycle n appears on hold_* at n+1).
REQ-028 WB_ARB_HOLD_EN undefined: hold_* ports present and tied to constant 0; no hold registers built.

Verification
REQ-029 Pipe only: pipe_we=1, addr 5, data 0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, pipe_stall=0.
REQ-030 Register 0: pipe_we=1 addr 0, then aux push addr 0 -> rf_we stays 0 throughout; FIFO drains to empty.
REQ-031 Starvation: pipe_we=1 continuously, one aux push addr 9 (STARVE_LIMIT=4) -> 4 pipe writes, then pipe_stall=1 for one cycle, aux write addr 9, then pipe resumes with held data.
REQ-032 Full FIFO: 3 consecutive aux_valid with pipe busy (AUX_DEPTH=2) -> aux_ready=0 after 2 pushes; 3rd accepted only after a pop; writes emerge in order.
REQ-033 Reset mid-queue: 2 aux entries pending, rst pulsed 1 cycle -> rf_we=0, count 0, queued writes never appear.
REQ-034 With WB_ARB_HOLD_EN: write addr 7 data 0x12 -> hold_we=1, hold_waddr=7, hold_wdata=0x12 one cycle after rf_*; without it, hold_* always 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges the MEM/WB pipeline write with a queued aux requester onto one RF write port.
// Optional macro WB_ARB_HOLD_EN builds a one-cycle-delayed copy of the RF write for ID-stage forwarding.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AUX_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  input  logic        aux_valid,
  input  logic [4:0]  aux_waddr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        hold_we,
  output logic [4:0]  hold_waddr,
  output logic [31:0] hold_wdata
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(AUX_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(AUX_DEPTH);
  localparam logic [3:0]       LIMIT_C = 4'(STARVE_LIMIT);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        starve_q, starve_d;
  logic [4:0]        fifo_addr_q [AUX_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [AUX_DEPTH];
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic pipe_req, fifo_nonempty, grant_aux, grant_pipe, push, pop;
  logic [4:0]        head_addr;
  logic [DATA_W-1:0] head_data;

  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    pipe_req      = pipe_we & (pipe_waddr != 5'd0);
    fifo_nonempty = (count_q != '0);
    // Aux wins when the pipe is idle or has starved it for STARVE_LIMIT cycles.
    grant_aux     = fifo_nonempty & (~pipe_req | (starve_q == LIMIT_C));
    grant_pipe    = pipe_req & ~grant_aux;
    aux_ready     = ~rst & (count_q < DEPTH_C);
    pipe_stall    = ~rst & pipe_req & grant_aux;
    push          = aux_valid & aux_ready;
    pop           = grant_aux;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    starve_d = starve_q;
    if (!fifo_nonempty || grant_aux)          starve_d = 4'd0;
    else if (grant_pipe && starve_q < LIMIT_C) starve_d = starve_q + 4'd1;

    // Aux writes to register 0 are popped but never reach the RF port.
    rf_we_d    = grant_pipe | (grant_aux & (head_addr != 5'd0));
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_pipe) begin
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (rf_we_d) begin
      rf_waddr_d = head_addr;
      rf_wdata_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= aux_waddr;
      fifo_data_q[wr_ptr_q] <= aux_wdata;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_ARB_HOLD_EN
  logic              hold_we_q, hold_we_d;
  logic [4:0]        hold_waddr_q, hold_waddr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;

  always_comb begin
    hold_we_d    = rf_we_q;
    hold_waddr_d = rf_waddr_q;
    hold_wdata_d = rf_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_we_q    <= 1'b0;
      hold_waddr_q <= '0;
      hold_wdata_q <= '0;
    end else begin
      hold_we_q    <= hold_we_d;
      hold_waddr_q <= hold_waddr_d;
      hold_wdata_q <= hold_wdata_d;
    end
  end

  assign hold_we    = hold_we_q;
  assign hold_waddr = hold_waddr_q;
  assign hold_wdata = hold_wdata_q;
`else
  assign hold_we    = 1'b0;
  assign hold_waddr = 5'd0;
  assign hold_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default STARVE_LIMIT=4, AUX_DEPTH=2).
module tb_wb_port_arbiter;

`ifdef WB_ARB_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        aux_valid;
  logic [4:0]  aux_waddr;
  logic [31:0] aux_wdata;
  logic        aux_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        hold_we;
  logic [4:0]  hold_waddr;
  logic [31:0] hold_wdata;

  int total  = 0;
  int passed = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4), .AUX_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall),
    .aux_valid(aux_valid), .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hold_we(hold_we), .hold_waddr(hold_waddr), .hold_wdata(hold_wdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, "_data"}, rf_wdata, d);
  endtask

  initial begin
    rst = 1'b1;
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    aux_valid = 1'b0; aux_waddr = '0; aux_wdata = '0;
    step();
    step();
    // Reset state
    chk_rf("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_aux_ready", 32'(aux_ready), 32'd0);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_hold_we", 32'(hold_we), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_aux_ready", 32'(aux_ready), 32'd1);

    // Pipe-only write
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
    #1;
    chk("pipe_only_stall", 32'(pipe_stall), 32'd0);
    step();
    chk_rf("pipe_only", 1'b1, 5'd5, 32'hDEADBEEF);
    pipe_we = 1'b0;
    step();
    chk_rf("idle_hold_last", 1'b0, 5'd5, 32'hDEADBEEF);
    chk("hold_we", 32'(hold_we), 32'(HOLD));
    chk("hold_waddr", 32'(hold_waddr), HOLD ? 32'd5 : 32'd0);
    chk("hold_wdata", hold_wdata, HOLD ? 32'hDEADBEEF : 32'd0);

    // Register 0 writes from both requesters are dropped
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h1111;
    step();
    chk("r0_pipe_we", 32'(rf_we), 32'd0);
    pipe_we = 1'b0;
    aux_valid = 1'b1; aux_waddr = 5'd0; aux_wdata = 32'h2222;
    step();
    aux_valid = 1'b0;
    chk("r0_push_we", 32'(rf_we), 32'd0);
    step();
    chk_rf("r0_aux", 1'b0, 5'd5, 32'hDEADBEEF);
    chk("r0_drained_ready", 32'(aux_ready), 32'd1);

    // Starvation bound: aux wins after 4 lost cycles
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h100;
    aux_valid = 1'b1; aux_waddr = 5'd9; aux_wdata = 32'h99;
    step();
    aux_valid = 1'b0;
    chk_rf("starve_push", 1'b1, 5'd3, 32'h100);
    for (int k = 1; k <= 4; k++) begin
      pipe_wdata = 32'h100 + 32'(k);
      #1;
      chk("starve_no_stall", 32'(pipe_stall), 32'd0);
      step();
      chk_rf("starve_pipe", 1'b1, 5'd3, 32'h100 + 32'(k));
    end
    pipe_wdata = 32'h105;
    #1;
    chk("starve_stall", 32'(pipe_stall), 32'd1);
    step();
    chk_rf("starve_aux", 1'b1, 5'd9, 32'h99);
    chk("starve_resume_stall", 32'(pipe_stall), 32'd0);
    step();
    chk_rf("starve_resume", 1'b1, 5'd3, 32'h105);

    // Full FIFO with pipe busy
    pipe_waddr = 5'd4; pipe_wdata = 32'h40;
    aux_valid = 1'b1; aux_waddr = 5'd10; aux_wdata = 32'hA0;
    step();
    aux_waddr = 5'd11; aux_wdata = 32'hA1;
    #1;
    chk("full_ready1", 32'(aux_ready), 32'd1);
    step();
    aux_waddr = 5'd12; aux_wdata = 32'hA2;
    #1;
    chk("full_ready0", 32'(aux_ready), 32'd0);
    chk("full_stall_c3", 32'(pipe_stall), 32'd0);
    step();
    chk_rf("full_pipe", 1'b1, 5'd4, 32'h40);
    chk("full_ready0_b", 32'(aux_ready), 32'd0);
    step();
    chk("full_stall_c5", 32'(pipe_stall), 32'd0);
    step();
    chk("full_stall_c6", 32'(pipe_stall), 32'd1);
    chk("full_ready0_c6", 32'(aux_ready), 32'd0);
    step();
    chk_rf("full_pop_a0", 1'b1, 5'd10, 32'hA0);
    pipe_we = 1'b0;
    #1;
    chk("full_ready_after_pop", 32'(aux_ready), 32'd1);
    step();
    aux_valid = 1'b0;
    chk_rf("full_pop_a1", 1'b1, 5'd11, 32'hA1);
    step();
    chk_rf("full_pop_a2", 1'b1, 5'd12, 32'hA2);
    step();
    chk("full_empty_we", 32'(rf_we), 32'd0);

    // Reset with two queued aux writes
    pipe_we = 1'b1; pipe_waddr = 5'd6; pipe_wdata = 32'h60;
    aux_valid = 1'b1; aux_waddr = 5'd20; aux_wdata = 32'hB0;
    step();
    aux_waddr = 5'd21; aux_wdata = 32'hB1;
    step();
    aux_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(aux_ready), 32'd0);
    chk("mid_rst_stall", 32'(pipe_stall), 32'd0);
    step();
    chk_rf("mid_rst", 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    pipe_we = 1'b0;
    #1;
    chk("mid_rst_count0", 32'(aux_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_rst_no_ghost", 32'(rf_we), 32'd0);
    end
    pipe_we = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'h12;
    step();
    pipe_we = 1'b0;
    chk_rf("after_rst_write", 1'b1, 5'd7, 32'h12);
    step();
    chk("hold7_we", 32'(hold_we), 32'(HOLD));
    chk("hold7_waddr", 32'(hold_waddr), HOLD ? 32'd7 : 32'd0);
    chk("hold7_wdata", hold_wdata, HOLD ? 32'h12 : 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
